// File: rtl/vector_element_sequencer_pkg.sv
// Shared types and default sizing for the vector element sequencer and the
// lane datapath it feeds.
package vector_element_sequencer_pkg;

    localparam int SEQ_NUM_LANES = 2;
    localparam int SEQ_VL_W      = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/vector_element_sequencer_if.sv
// Element-group bus from the sequencer (seq side) to the execute lanes (lane side).
interface vector_element_sequencer_if
    import vector_element_sequencer_pkg::*;
#(
    parameter int NUM_LANES = SEQ_NUM_LANES,
    parameter int VL_W      = SEQ_VL_W
);

    logic                                busy;
    logic                                valid;
    logic [NUM_LANES-1:0][VL_W-1:0]      elem_offset;
    logic [NUM_LANES-1:0][VL_W-1:0]      vd_offset;
    logic [NUM_LANES-1:0]                lane_active;
    logic                                last;
    logic                                done;
    logic                                vstart_clear;

    modport seq (
        output busy, valid, elem_offset, vd_offset, lane_active, last, done, vstart_clear
    );

    modport lane (
        input busy, valid, elem_offset, vd_offset, lane_active, last, done, vstart_clear
    );

endinterface

// File: rtl/vector_element_sequencer.sv
// Walks a vector instruction's elements from vstart to vl in groups of NUM_LANES,
// driving registered per-lane offsets and completion pulses to the execute lanes.
module vector_element_sequencer
    import vector_element_sequencer_pkg::*;
#(
    parameter int NUM_LANES = SEQ_NUM_LANES,
    parameter int VL_W      = SEQ_VL_W
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    de_en,
    input  logic [VL_W-1:0]         vl,
    input  logic [VL_W-1:0]         vstart,
    input  logic                    vd_widen,
    input  logic                    stall,
    input  logic                    flush,
    vector_element_sequencer_if.seq seq_bus
);

    localparam logic [VL_W:0] LANES_EXT = (VL_W+1)'(NUM_LANES);

    seq_state_t                     state_r, state_s;
    logic [VL_W-1:0]                base_r, base_s;
    logic [VL_W-1:0]                vl_r, vl_s;
    logic                           widen_r, widen_s;
    logic                           last_grp_s;
    logic                           done_s;

    logic [NUM_LANES-1:0][VL_W-1:0] elem_s, vd_s;
    logic [NUM_LANES-1:0]           act_s;
    logic                           last_s;

    logic                           busy_r, valid_r, last_r, done_r, clr_r;
    logic [NUM_LANES-1:0][VL_W-1:0] elem_r, vd_r;
    logic [NUM_LANES-1:0]           act_r;

    // Extra MSB keeps base+NUM_LANES from wrapping when vl is near 2^VL_W-1.
    assign last_grp_s = (({1'b0, base_r} + LANES_EXT) >= {1'b0, vl_r});

    // Next-state logic: flush dominates, stall freezes, otherwise advance one group.
    always_comb begin
        state_s = state_r;
        base_s  = base_r;
        vl_s    = vl_r;
        widen_s = widen_r;
        done_s  = 1'b0;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (de_en) begin
                        if (vstart >= vl) begin
                            done_s = 1'b1;
                        end else begin
                            state_s = RUN;
                            base_s  = vstart;
                            vl_s    = vl;
                            widen_s = vd_widen;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (stall) begin
                        state_s = RUN;
                    end else if (last_grp_s) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        base_s = base_r + VL_W'(NUM_LANES);
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Output-stage values for the group that will be presented next cycle.
    always_comb begin
        elem_s = '0;
        vd_s   = '0;
        act_s  = '0;
        last_s = 1'b0;
        if (state_s == RUN) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                elem_s[i] = base_s + VL_W'(i);
                vd_s[i]   = widen_s ? {elem_s[i][VL_W-2:0], 1'b0} : elem_s[i];
                act_s[i]  = (({1'b0, base_s} + (VL_W+1)'(i)) < {1'b0, vl_s});
            end
            last_s = (({1'b0, base_s} + LANES_EXT) >= {1'b0, vl_s});
        end else begin
            last_s = 1'b0;
        end
    end

    // Control state and the latched instruction context.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            base_r  <= '0;
            vl_r    <= '0;
            widen_r <= 1'b0;
        end else begin
            state_r <= state_s;
            base_r  <= base_s;
            vl_r    <= vl_s;
            widen_r <= widen_s;
        end
    end

    // Registered lane-facing outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            clr_r   <= 1'b0;
            elem_r  <= '0;
            vd_r    <= '0;
            act_r   <= '0;
        end else begin
            busy_r  <= (state_s == RUN);
            valid_r <= (state_s == RUN);
            last_r  <= last_s;
            done_r  <= done_s;
            clr_r   <= done_s;
            elem_r  <= elem_s;
            vd_r    <= vd_s;
            act_r   <= act_s;
        end
    end

    assign seq_bus.busy         = busy_r;
    assign seq_bus.valid        = valid_r;
    assign seq_bus.last         = last_r;
    assign seq_bus.done         = done_r;
    assign seq_bus.vstart_clear = clr_r;
    assign seq_bus.elem_offset  = elem_r;
    assign seq_bus.vd_offset    = vd_r;
    assign seq_bus.lane_active  = act_r;

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Directed and randomized checks of vector_element_sequencer against a group-list
// reference computed from vl/vstart arithmetic.
module tb_vector_element_sequencer;

    localparam int N = 2;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         de_en = 1'b0;
    logic [W-1:0] vl = '0;
    logic [W-1:0] vstart = '0;
    logic         vd_widen = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;

    int checks = 0;
    int failures = 0;

    vector_element_sequencer_if #(.NUM_LANES(N), .VL_W(W)) seq_if ();

    vector_element_sequencer #(.NUM_LANES(N), .VL_W(W)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .de_en   (de_en),
        .vl      (vl),
        .vstart  (vstart),
        .vd_widen(vd_widen),
        .stall   (stall),
        .flush   (flush),
        .seq_bus (seq_if)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Expected group starting at element index base.
    task automatic check_group(input string tag, input int base, input int len, input bit w);
        logic [31:0] e_elem, e_vd, e_act;
        e_elem = '0;
        e_vd   = '0;
        e_act  = '0;
        for (int i = 0; i < N; i++) begin
            e_elem[i*W +: W] = W'(base + i);
            e_vd[i*W +: W]   = w ? W'(2 * (base + i)) : W'(base + i);
            e_act[i]         = ((base + i) < len);
        end
        chk({tag, ".valid"}, 32'(seq_if.valid), 32'd1);
        chk({tag, ".busy"},  32'(seq_if.busy), 32'd1);
        chk({tag, ".elem"},  32'(seq_if.elem_offset), e_elem);
        chk({tag, ".vd"},    32'(seq_if.vd_offset), e_vd);
        chk({tag, ".act"},   32'(seq_if.lane_active), e_act);
        chk({tag, ".last"},  32'(seq_if.last), 32'((base + N) >= len));
        chk({tag, ".done"},  32'(seq_if.done), 32'd0);
        chk({tag, ".vclr"},  32'(seq_if.vstart_clear), 32'd0);
    endtask

    task automatic check_idle(input string tag, input bit done_exp);
        chk({tag, ".valid"}, 32'(seq_if.valid), 32'd0);
        chk({tag, ".busy"},  32'(seq_if.busy), 32'd0);
        chk({tag, ".elem"},  32'(seq_if.elem_offset), 32'd0);
        chk({tag, ".vd"},    32'(seq_if.vd_offset), 32'd0);
        chk({tag, ".act"},   32'(seq_if.lane_active), 32'd0);
        chk({tag, ".last"},  32'(seq_if.last), 32'd0);
        chk({tag, ".done"},  32'(seq_if.done), 32'(done_exp));
        chk({tag, ".vclr"},  32'(seq_if.vstart_clear), 32'(done_exp));
    endtask

    task automatic idle_cycle(input string tag);
        stall = 1'($urandom_range(1));
        step();
        stall = 1'b0;
        check_idle(tag, 1'b0);
    endtask

    // Issue one instruction at the current negedge; return at the negedge showing done.
    task automatic run_instr(input string tag, input int len, input int vs, input bit w,
                             input logic [31:0] stall_mask);
        int  base;
        int  busy_cyc;
        int  stalls;
        int  groups;
        bit  finished;
        de_en    = 1'b1;
        vl       = W'(len);
        vstart   = W'(vs);
        vd_widen = w;
        step();
        de_en    = 1'b0;
        vd_widen = 1'b0;
        if (vs >= len) begin
            check_idle({tag, ".empty"}, 1'b1);
        end else begin
            base     = vs;
            busy_cyc = 0;
            stalls   = 0;
            finished = 1'b0;
            groups   = (len - vs + N - 1) / N;
            for (int c = 0; c < 200 && !finished; c++) begin
                check_group(tag, base, len, w);
                busy_cyc++;
                stall = (c < 32) ? stall_mask[c] : 1'b0;
                step();
                if (stall) begin
                    stalls++;
                end else if (base + N >= len) begin
                    finished = 1'b1;
                end else begin
                    base += N;
                end
                stall = 1'b0;
            end
            chk({tag, ".finished"}, 32'(finished), 32'd1);
            chk({tag, ".busy_cycles"}, 32'(busy_cyc), 32'(groups + stalls));
            check_idle({tag, ".end"}, 1'b1);
        end
    endtask

    initial begin
        int len, vs, gap;
        bit w;
        logic [31:0] mask;

        step();
        step();
        check_idle("reset", 1'b0);
        nRST = 1'b1;
        idle_cycle("post_reset");

        run_instr("vl5", 5, 0, 1'b0, 32'h0);
        idle_cycle("vl5_after");
        run_instr("vl4_vs3", 4, 3, 1'b0, 32'h0);
        idle_cycle("vl4_vs3_after");
        run_instr("vs_eq_vl", 4, 4, 1'b0, 32'h0);
        idle_cycle("vs_eq_vl_after");
        run_instr("vl6_stall", 6, 0, 1'b0, 32'h6);
        idle_cycle("vl6_stall_after");
        run_instr("widen", 3, 0, 1'b1, 32'h0);
        idle_cycle("widen_after");

        // Flush in the second RUN cycle.
        de_en = 1'b1; vl = 8'd8; vstart = 8'd0;
        step();
        de_en = 1'b0;
        check_group("flush_g0", 0, 8, 1'b0);
        step();
        check_group("flush_g1", 2, 8, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_idle("flush", 1'b0);
        idle_cycle("flush_nodone");
        run_instr("after_flush", 2, 0, 1'b0, 32'h0);

        // Flush together with de_en from IDLE drops the request.
        flush = 1'b1; de_en = 1'b1; vl = 8'd4; vstart = 8'd0;
        step();
        flush = 1'b0; de_en = 1'b0;
        check_idle("flush_de", 1'b0);
        idle_cycle("flush_de_after");

        // Back-to-back issue in the done cycle.
        run_instr("b2b_a", 3, 1, 1'b0, 32'h0);
        run_instr("b2b_b", 2, 0, 1'b1, 32'h0);
        idle_cycle("b2b_after");

        // Asynchronous reset between edges mid-instruction.
        de_en = 1'b1; vl = 8'd8; vstart = 8'd0;
        step();
        de_en = 1'b0;
        check_group("rst_g0", 0, 8, 1'b0);
        #2 nRST = 1'b0;
        #1 check_idle("async_rst", 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        idle_cycle("rst_release");
        run_instr("after_rst", 1, 0, 1'b0, 32'h0);
        idle_cycle("after_rst_idle");

        // Boundaries near the top of the index range and vl=0.
        run_instr("top_251", 255, 251, 1'b1, 32'h0);
        run_instr("top_253", 255, 253, 1'b0, 32'h0);
        run_instr("vl0", 0, 0, 1'b0, 32'h0);
        idle_cycle("bound_after");

        for (int k = 0; k < 40; k++) begin
            len  = ($urandom_range(7) == 0) ? int'($urandom_range(255, 240)) : int'($urandom_range(20));
            vs   = (len >= 12) ? len - int'($urandom_range(12)) : int'($urandom_range(len + 1));
            w    = 1'($urandom_range(1));
            mask = $urandom & $urandom;
            run_instr("rand", len, vs, w, mask);
            gap = int'($urandom_range(2));
            for (int g = 0; g < gap; g++) begin
                idle_cycle("rand_idle");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_element_sequencer.md
Name: vector_element_sequencer

Overview:
- Sits directly downstream of vector decode; consumes the decoded instruction's vl/vstart and widening flags on de_en.
- Walks element indices in groups of NUM_LANES per cycle and drives per-lane element offsets, lane-active bits and a last/done indication into the vector execute lanes.
- Holds decode off (busy) until the instruction's final element group issues.

Parameters:
- NUM_LANES, 2, elements issued per cycle (power of two, ≥1)
- VL_W, 8, width of vl/vstart/element indices (VLMAX ≤ 2^VL_W − 1)

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- de_en  input  1  decoded vector instruction valid (start request)
- vl  input  VL_W  vector length for this instruction
- vstart  input  VL_W  first element index
- vd_widen  input  1  destination elements are 2*SEW (vd offset doubled)
- stall  input  1  downstream cannot accept a group this cycle
- flush  input  1  kill in-flight instruction (exception/branch)
- busy  output  1  sequencer owns an instruction; decode must hold
- valid  output  1  element group on outputs is valid
- elem_offset  output  NUM_LANES x VL_W  source element index per lane
- vd_offset  output  NUM_LANES x VL_W  destination element slot per lane
- lane_active  output  NUM_LANES  lane i carries a real element
- last  output  1  current group is the instruction's final group
- done  output  1  one-cycle pulse: instruction fully issued
- vstart_clear  output  1  one-cycle pulse requesting CSR vstart := 0

Behaviour:
- Reset (nRST low, async): state IDLE; busy, valid, last, done, vstart_clear, lane_active = 0; elem_offset, vd_offset = 0. Reset mid-instruction abandons it silently.
- States: IDLE, RUN.
- IDLE: busy=0, valid=0. On de_en:
  - if vstart ≥ vl: stay IDLE; next cycle done=1, vstart_clear=1, valid=0 (no elements issued).
  - else latch vl; base := vstart; go RUN. First group is registered: valid in cycle after de_en (latency 1).
- RUN: busy=1, valid=1. Lane i: elem_offset[i] = base+i; lane_active[i] = (base+i < vl); vd_offset[i] = vd_widen ? (base+i)<<1 : base+i (truncated to VL_W).
  - last = (base+NUM_LANES ≥ vl), computed without overflow (VL_W+1 bits).
  - stall=1: hold every output and base unchanged; done not asserted.
  - stall=0 and !last: base += NUM_LANES.
  - stall=0 and last: go IDLE; done=1 and vstart_clear=1 in the following cycle.
- Partial final group: inactive lanes have lane_active=0; their offsets still show base+i (don't-care to consumers).
- de_en while busy=1: ignored (decode must gate on busy). de_en in the cycle done pulses is accepted (back-to-back issue, no bubble beyond the registration cycle).
- flush: highest priority after reset. Any state → IDLE next cycle, all outputs cleared, no done/vstart_clear pulse. flush and de_en together: flush wins, de_en dropped.
- stall while IDLE: no effect.
- vl=0: covered by vstart ≥ vl path.
- vstart nonzero and unaligned to NUM_LANES: groups start at vstart, not rounded down.

Decomposition:
- rv32v_types_pkg: add seq_state_t enum (IDLE, RUN) and NUM_LANES constant shared with lane datapath.
- Interface vector_element_sequencer_if grouping the outputs, with modports seq (output side) and lane (input side).
- No sub-module; single FSM + offset counter.

Test Plan:
- vl=5, vstart=0, NUM_LANES=2, no stall → groups {0,1},{2,3},{4,x}; lane_active 11,11,01; last on 3rd group; done one cycle later; busy high exactly 3 cycles.
- vl=4, vstart=3 → single group {3,4}, lane_active=01, last=1, done and vstart_clear pulse; vstart=4, vl=4 → no valid, done next cycle.
- vl=6, stall high for 2 cycles during 2nd group → group {2,3} held unchanged 3 cycles, then {4,5} with last; total busy 5 cycles.
- vd_widen=1, vl=3 → vd_offset {0,2},{4,6}, elem_offset {0,1},{2,3}, lane_active 11,01.
- flush in 2nd RUN cycle of vl=8 → next cycle IDLE, valid=0, no done/vstart_clear; new de_en with vl=2 then issues {0,1} normally.
- nRST asserted mid-RUN (asynchronously, between edges) → outputs zero immediately; after release, de_en with vl=1 → one group, lane_active=01, done pulse.
